// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM encoding for the restoring divider
//   DW_DEF : dividend/quotient width, VW_DEF : divisor/remainder width
//   CW_DEF : iteration counter width, S_* : FSM state codes
package div_pkg;
   localparam int DW_DEF = 16;
   localparam int VW_DEF = 8;
   localparam int CW_DEF = $clog2(DW_DEF);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, trial subtract)
//   p     : partial remainder (VW+1 bits, always < v so its MSB is 0)
//   din   : next dividend bit, entering at the LSB
//   v     : divisor
//   p_nxt : updated partial remainder, qb : quotient bit
module div_step #(
   parameter int VW = 8
) (
   input  logic [VW:0]   p,
   input  logic          din,
   input  logic [VW-1:0] v,
   output logic [VW:0]   p_nxt,
   output logic          qb
);
   // The full P is shifted so every bit is used; its MSB is always 0, so the
   // truncation back to VW+1 bits is exact.
   logic [VW+1:0] t;
   always_comb begin
      t     = {p, din};
      qb    = t >= (VW+2)'(v);
      p_nxt = (VW+1)'(qb ? t - (VW+2)'(v) : t);
   end
endmodule

// File: rtl/restoring_div_16by8.sv
// restoring_div_16by8: sequential restoring divider, one quotient bit per clock
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, accepted when not busy
//   dividend/divisor: operands, captured when start is accepted
//   busy, done      : iterating / one-cycle completion pulse
//   Q, R, dbz       : quotient, remainder, divide-by-zero (held until next completion)
module restoring_div_16by8
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] Q,
   output logic [VW-1:0] R,
   output logic          dbz
);
   localparam int CW = $clog2(DW);
   logic [1:0]    state;
   logic [DW-1:0] d;
   logic [VW-1:0] v;
   logic [VW:0]   p, p_nxt;
   logic [CW-1:0] cnt;
   logic          qb;
   div_step #(.VW(VW)) u_step (.p(p), .din(d[DW-1]), .v(v), .p_nxt(p_nxt), .qb(qb));
   assign busy = state == S_RUN;
   assign done = state == S_DONE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         d     <= '0;
         v     <= '0;
         p     <= '0;
         cnt   <= '0;
         Q     <= '0;
         R     <= '0;
         dbz   <= 1'b0;
      end else if (state != S_RUN && start) begin
         if (divisor == '0) begin
            state <= S_DONE;
            Q     <= '1;
            R     <= dividend[VW-1:0];
            dbz   <= 1'b1;
         end else begin
            state <= S_RUN;
            d     <= dividend;
            v     <= divisor;
            p     <= '0;
            cnt   <= '0;
         end
      end else if (state == S_RUN) begin
         d   <= {d[DW-2:0], qb};
         p   <= p_nxt;
         cnt <= cnt + 1'b1;
         if (cnt == CW'(DW-1)) begin
            state <= S_DONE;
            Q     <= {d[DW-2:0], qb};
            R     <= p_nxt[VW-1:0];
            dbz   <= 1'b0;
         end
      end else begin
         state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_restoring_div_16by8.sv
// tb_restoring_div_16by8: directed and random checks against an arithmetic model
module tb_restoring_div_16by8;
   logic        clk = 0, rst_n = 0, start = 0;
   logic [15:0] dividend = 0, Q;
   logic [7:0]  divisor = 0, R;
   logic        busy, done, dbz;
   int          n_chk = 0, n_pass = 0;
   logic        chk_en = 0;

   restoring_div_16by8 dut (.clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
      .divisor(divisor), .busy(busy), .done(done), .Q(Q), .R(R), .dbz(dbz));

   always #5 clk = ~clk;

   // behavioural model: fixed 16-cycle latency, result from plain / and %
   logic        m_busy, m_done, m_dbz;
   logic [15:0] m_q, m_a;
   logic [7:0]  m_r, m_b;
   int          m_left;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_done <= 0; m_dbz <= 0; m_q <= 0; m_r <= 0; m_left <= 0;
      end else if (!m_busy && start) begin
         if (divisor == 0) begin
            m_done <= 1; m_q <= 16'hFFFF; m_r <= dividend[7:0]; m_dbz <= 1;
         end else begin
            m_busy <= 1; m_done <= 0; m_left <= 16; m_a <= dividend; m_b <= divisor;
         end
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 0; m_done <= 1; m_dbz <= 0;
            m_q <= m_a / 16'(m_b); m_r <= 8'(m_a % 16'(m_b));
         end
      end else begin
         m_done <= 0;
      end
   end

   always @(negedge clk) if (chk_en) begin
      n_chk++;
      if ({busy, done, Q, R, dbz} === {m_busy, m_done, m_q, m_r, m_dbz}) n_pass++;
      else $display("FAIL cycle-model t=%0t got busy=%b done=%b Q=%0d R=%0d dbz=%b want busy=%b done=%b Q=%0d R=%0d dbz=%b",
         $time, busy, done, Q, R, dbz, m_busy, m_done, m_q, m_r, m_dbz);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d want=%0d", name, got, exp);
   endtask

   // called at a negedge; returns at the negedge where done is seen
   task automatic op(input logic [15:0] a, input logic [7:0] b,
                     output logic [15:0] q, output logic [7:0] r, output logic z, output int lat);
      start = 1; dividend = a; divisor = b;
      @(posedge clk);
      @(negedge clk);
      start = 0;
      lat = 0;
      while (!done && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      if (lat >= 40) chk("timeout", 32'(lat), 32'd16);
      q = Q; r = R; z = dbz;
   endtask

   logic [15:0] q, a;
   logic [7:0]  r, b;
   logic        z;
   int          lat;

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_QR", {Q, R, 7'd0, dbz}, 0);
      rst_n = 1;
      @(negedge clk);
      op(62500, 250, q, r, z, lat);
      chk("62500/250 Q", 32'(q), 250); chk("62500/250 R", 32'(r), 0);
      chk("62500/250 dbz", 32'(z), 0); chk("62500/250 lat", 32'(lat), 16);
      @(negedge clk);
      op(65535, 1, q, r, z, lat);
      chk("65535/1 Q", 32'(q), 65535); chk("65535/1 R", 32'(r), 0);
      op(65535, 255, q, r, z, lat);
      chk("65535/255 Q", 32'(q), 257); chk("65535/255 R", 32'(r), 0);
      op(1000, 7, q, r, z, lat);
      chk("1000/7 Q", 32'(q), 142); chk("1000/7 R", 32'(r), 6);
      op(7, 9, q, r, z, lat);
      chk("7/9 Q", 32'(q), 0); chk("7/9 R", 32'(r), 7); chk("7/9 lat", 32'(lat), 16);
      op(0, 5, q, r, z, lat);
      chk("0/5 QR", {q, r}, 0); chk("0/5 lat", 32'(lat), 16);
      @(negedge clk);
      op(100, 0, q, r, z, lat);
      chk("100/0 Q", 32'(q), 32'hFFFF); chk("100/0 R", 32'(r), 100);
      chk("100/0 dbz", 32'(z), 1); chk("100/0 lat", 32'(lat), 0); chk("100/0 busy", 32'(busy), 0);
      // second request during RUN must be ignored
      @(negedge clk);
      start = 1; dividend = 500; divisor = 3;
      @(negedge clk);
      start = 0;
      repeat (3) @(negedge clk);
      start = 1; dividend = 9; divisor = 9;
      @(negedge clk);
      start = 0;
      lat = 0;
      while (!done && lat < 40) begin lat++; @(negedge clk); end
      chk("500/3 Q", 32'(Q), 166); chk("500/3 R", 32'(R), 2);
      op(9, 9, q, r, z, lat);
      chk("9/9 Q", 32'(q), 1); chk("9/9 R", 32'(r), 0);
      // reset mid-run aborts
      @(negedge clk);
      start = 1; dividend = 62500; divisor = 250;
      @(negedge clk);
      start = 0;
      repeat (7) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("abort busy", 32'(busy), 0);
      chk("abort QR", {Q, R, 7'd0, dbz}, 0);
      repeat (3) begin @(negedge clk); chk("abort done", 32'(done), 0); end
      rst_n = 1;
      @(negedge clk);
      op(81, 9, q, r, z, lat);
      chk("81/9 Q", 32'(q), 9); chk("81/9 R", 32'(r), 0);
      // inverse of the multiplier: (A*B)/B == A
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom_range(0, 255));
         b = 8'($urandom_range(1, 255));
         op(a * 16'(b), b, q, r, z, lat);
         chk("prod Q", 32'(q), 32'(a));
         chk("prod R", 32'(r), 0);
      end
      // random pairs: invariant dividend == Q*divisor + R, R < divisor
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         op(a, b, q, r, z, lat);
         if (b == 0) chk("rand dbz Q", 32'(q), 32'hFFFF);
         else begin
            chk("rand inv", 32'(q) * 32'(b) + 32'(r), 32'(a));
            chk("rand R<B", 32'(r < b), 1);
         end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
